deserializer: RTL and testbench

//  Receive end of the serial link driven by the team's serializer: samples ser_data_i (MSB first)

---
 rtl/ser_link_pkg.sv | 30 +++
 rtl/deserializer.sv | 148 ++++++++++++++
 tb/tb_deserializer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ser_link_pkg.sv
// ----------------------------------------------------------------------------
// ser_link_pkg
// Shared definitions for the serial link (serializer / deserializer pair):
// default word width, minimum legal frame length, data_mod <-> bit-count
// helpers and the receiver state encoding.
// ----------------------------------------------------------------------------
package ser_link_pkg;

    localparam int unsigned SER_DATA_W  = 16;
    localparam int unsigned SER_MIN_LEN = 3;
    localparam int unsigned SER_MOD_W   = $clog2(SER_DATA_W);
    // One extra bit so a full-word count is representable.
    localparam int unsigned SER_CNT_W   = SER_MOD_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } deser_state_t;

    // Bit count -> data_mod encoding (a full word encodes as 0).
    function automatic logic [SER_MOD_W-1:0] cnt_to_mod(input logic [SER_CNT_W-1:0] cnt);
        return (cnt == SER_CNT_W'(SER_DATA_W)) ? '0 : SER_MOD_W'(cnt);
    endfunction

    // data_mod -> bit count (0 decodes to a full word).
    function automatic logic [SER_CNT_W-1:0] mod_to_cnt(input logic [SER_MOD_W-1:0] mod);
        return (mod == '0) ? SER_CNT_W'(SER_DATA_W) : SER_CNT_W'(mod);
    endfunction

endpackage : ser_link_pkg

// File: rtl/deserializer.sv
// ----------------------------------------------------------------------------
// deserializer
// Receive side of the serial link. Shifts in ser_data_i (MSB first) while
// ser_data_val_i is high and emits the rebuilt, left-justified word with its
// bit count in data_mod encoding (0 = full word). One strobe per frame;
// frames shorter than MIN_LEN bits (runts) are dropped.
//
// Ports:
//   clk_i             clock, rising edge
//   rst_n_i           asynchronous active-low reset
//   ser_data_i        serial data bit, MSB first
//   ser_data_val_i    ser_data_i valid this cycle
//   deser_data_o      received word, left-justified, unreceived LSBs = 0
//   deser_data_mod_o  bits received, 0 encodes DATA_W
//   deser_data_val_o  one-cycle strobe qualifying data/mod
//   busy_o            frame in progress
//   frame_err_o       runt-frame strobe (only when DESER_FRAME_ERR_EN is defined)
//
// Configuration macro: DESER_FRAME_ERR_EN adds the frame_err_o port.
// ----------------------------------------------------------------------------
module deserializer
    import ser_link_pkg::*;
#(
    parameter int unsigned DATA_W  = SER_DATA_W,
    parameter int unsigned MIN_LEN = SER_MIN_LEN
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      ser_data_i,
    input  logic                      ser_data_val_i,
    output logic [DATA_W-1:0]         deser_data_o,
    output logic [$clog2(DATA_W)-1:0] deser_data_mod_o,
    output logic                      deser_data_val_o,
    output logic                      busy_o
`ifdef DESER_FRAME_ERR_EN
   ,output logic                      frame_err_o
`endif
);

    localparam int unsigned MOD_W = $clog2(DATA_W);
    localparam int unsigned CNT_W = MOD_W + 1;

    deser_state_t      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [MOD_W-1:0]  mod_q,   mod_d;
    logic              val_q,   val_d;
`ifdef DESER_FRAME_ERR_EN
    logic              err_q,   err_d;
`endif

    // Next-state, capture and output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        mod_d   = mod_q;
        val_d   = 1'b0;
`ifdef DESER_FRAME_ERR_EN
        err_d   = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (ser_data_val_i) begin
                    // First bit of a frame; shift reg is already clear here.
                    state_d = RECV;
                    cnt_d   = CNT_W'(1);
                    shift_d = {{(DATA_W-1){1'b0}}, ser_data_i};
                end
            end

            RECV: begin
                if (ser_data_val_i) begin
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        // Last bit of a full word: emit and return to IDLE so a
                        // following valid bit starts the next frame with no gap.
                        data_d  = {shift_q[DATA_W-2:0], ser_data_i};
                        mod_d   = '0;
                        val_d   = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                        shift_d = '0;
                    end else begin
                        shift_d = {shift_q[DATA_W-2:0], ser_data_i};
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end else begin
                    // Frame ended early: emit a partial word or drop a runt.
                    if (cnt_q >= CNT_W'(MIN_LEN)) begin
                        data_d = shift_q << (CNT_W'(DATA_W) - cnt_q);
                        mod_d  = MOD_W'(cnt_q);
                        val_d  = 1'b1;
                    end else begin
`ifdef DESER_FRAME_ERR_EN
                        err_d  = 1'b1;
`endif
                    end
                    state_d = IDLE;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                shift_d = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            mod_q   <= '0;
            val_q   <= 1'b0;
`ifdef DESER_FRAME_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            mod_q   <= mod_d;
            val_q   <= val_d;
`ifdef DESER_FRAME_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    assign deser_data_o     = data_q;
    assign deser_data_mod_o = mod_q;
    assign deser_data_val_o = val_q;
    assign busy_o           = (state_q == RECV);
`ifdef DESER_FRAME_ERR_EN
    assign frame_err_o      = err_q;
`endif

endmodule : deserializer

// File: tb/tb_deserializer.sv
// ----------------------------------------------------------------------------
// tb_deserializer
// Directed bench for the deserializer: full, partial, runt, back-to-back and
// mid-frame reset frames, plus a short run of random frames shaped like the
// serializer would send them. Inputs change on the falling edge; outputs are
// checked on the falling edge after the rising edge that produced them.
// Define DESER_FRAME_ERR_EN to also check frame_err_o.
// ----------------------------------------------------------------------------
module tb_deserializer;
    import ser_link_pkg::*;

    localparam int unsigned DW = SER_DATA_W;
    localparam int unsigned MW = SER_MOD_W;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          ser_data_i;
    logic          ser_data_val_i;
    logic [DW-1:0] deser_data_o;
    logic [MW-1:0] deser_data_mod_o;
    logic          deser_data_val_o;
    logic          busy_o;
`ifdef DESER_FRAME_ERR_EN
    logic          frame_err_o;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    deserializer dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .ser_data_i       (ser_data_i),
        .ser_data_val_i   (ser_data_val_i),
        .deser_data_o     (deser_data_o),
        .deser_data_mod_o (deser_data_mod_o),
        .deser_data_val_o (deser_data_val_o),
        .busy_o           (busy_o)
`ifdef DESER_FRAME_ERR_EN
       ,.frame_err_o      (frame_err_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic b);
        @(negedge clk_i);
        ser_data_val_i = v;
        ser_data_i     = b;
    endtask

    // Send the top n bits of w, MSB first, with valid held high.
    task automatic send_bits(input logic [DW-1:0] w, input int n);
        for (int i = 0; i < n; i++) drive(1'b1, w[DW-1-i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] words [2];
        int            strobes;
        int            idx [2];
        logic [DW-1:0] word;
        logic [DW-1:0] mask;
        logic [MW-1:0] mod;
        int            len;

        rst_n_i        = 1'b0;
        ser_data_i     = 1'b0;
        ser_data_val_i = 1'b0;
        repeat (3) @(negedge clk_i);

        // Reset state
        check_eq("rst_data", 32'(deser_data_o), 32'h0);
        check_eq("rst_mod",  32'(deser_data_mod_o), 32'h0);
        check_eq("rst_val",  32'(deser_data_val_o), 32'h0);
        check_eq("rst_busy", 32'(busy_o), 32'h0);
`ifdef DESER_FRAME_ERR_EN
        check_eq("rst_err",  32'(frame_err_o), 32'h0);
`endif
        @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // Full 16-bit frame: strobe one cycle after bit 16
        send_bits(16'hA5C3, 16);
        check_eq("full_busy", 32'(busy_o), 32'h1);
        check_eq("full_early", 32'(deser_data_val_o), 32'h0);
        drive(1'b0, 1'b0);
        check_eq("full_val",  32'(deser_data_val_o), 32'h1);
        check_eq("full_data", 32'(deser_data_o), 32'hA5C3);
        check_eq("full_mod",  32'(deser_data_mod_o), 32'h0);
        check_eq("full_idle", 32'(busy_o), 32'h0);
        drive(1'b0, 1'b0);
        check_eq("full_1cyc", 32'(deser_data_val_o), 32'h0);
        check_eq("full_hold", 32'(deser_data_o), 32'hA5C3);

        // Short frame 1,0,1,1,0
        send_bits(16'hB000, 5);
        drive(1'b0, 1'b0);
        check_eq("short_early", 32'(deser_data_val_o), 32'h0);
        check_eq("short_busy",  32'(busy_o), 32'h1);
        drive(1'b0, 1'b0);
        check_eq("short_val",  32'(deser_data_val_o), 32'h1);
        check_eq("short_data", 32'(deser_data_o), 32'hB000);
        check_eq("short_mod",  32'(deser_data_mod_o), 32'h5);
        check_eq("short_idle", 32'(busy_o), 32'h0);
        drive(1'b0, 1'b0);
        check_eq("short_1cyc", 32'(deser_data_val_o), 32'h0);

        // Runt frame of 2 bits
        send_bits(16'hC000, 2);
        check_eq("runt_busy", 32'(busy_o), 32'h1);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        check_eq("runt_val",  32'(deser_data_val_o), 32'h0);
        check_eq("runt_idle", 32'(busy_o), 32'h0);
        check_eq("runt_hold", 32'(deser_data_o), 32'hB000);
`ifdef DESER_FRAME_ERR_EN
        check_eq("runt_err", 32'(frame_err_o), 32'h1);
`endif
        drive(1'b0, 1'b0);
        check_eq("runt_val2", 32'(deser_data_val_o), 32'h0);
`ifdef DESER_FRAME_ERR_EN
        check_eq("runt_err_1cyc", 32'(frame_err_o), 32'h0);
`endif

        // Back-to-back full frames FFFF then 0001 with no gap
        words[0] = 16'hFFFF;
        words[1] = 16'h0001;
        strobes  = 0;
        idx[0]   = -1;
        idx[1]   = -1;
        for (int i = 0; i <= 32; i++) begin
            if (i < 32) drive(1'b1, words[i/16][DW-1-(i%16)]);
            else        drive(1'b0, 1'b0);
            if (deser_data_val_o) begin
                if (strobes < 2) begin
                    check_eq("b2b_data", 32'(deser_data_o), 32'(words[strobes]));
                    check_eq("b2b_mod",  32'(deser_data_mod_o), 32'h0);
                    idx[strobes] = i;
                end
                strobes++;
            end
        end
        check_eq("b2b_count", 32'(strobes), 32'd2);
        check_eq("b2b_first", 32'(idx[0]), 32'd16);
        check_eq("b2b_gap",   32'(idx[1] - idx[0]), 32'd16);
        drive(1'b0, 1'b0);

        // Reset after 7 bits: outputs clear immediately, then a 4-bit frame
        send_bits(16'hFE00, 7);
        #2 rst_n_i = 1'b0;
        #1;
        check_eq("mrst_data", 32'(deser_data_o), 32'h0);
        check_eq("mrst_mod",  32'(deser_data_mod_o), 32'h0);
        check_eq("mrst_busy", 32'(busy_o), 32'h0);
        check_eq("mrst_val",  32'(deser_data_val_o), 32'h0);
        drive(1'b0, 1'b0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        send_bits(16'h9000, 4);
        drive(1'b0, 1'b0);
        check_eq("mrst_nostrobe", 32'(deser_data_val_o), 32'h0);
        drive(1'b0, 1'b0);
        check_eq("post_val",  32'(deser_data_val_o), 32'h1);
        check_eq("post_data", 32'(deser_data_o), 32'h9000);
        check_eq("post_mod",  32'(deser_data_mod_o), 32'h4);

        // Random frames shaped like serializer output (mod 0 or 3..15)
        for (int f = 0; f < 10; f++) begin
            int r;
            r    = int'($urandom_range(0, 13));
            mod  = (r == 0) ? MW'(0) : MW'(r + 2);
            len  = int'(mod_to_cnt(mod));
            word = DW'($urandom);
            mask = 16'hFFFF;
            mask = mask << (DW - len);
            drive(1'b0, 1'b0);
            send_bits(word, len);
            drive(1'b0, 1'b0);
            if (len < int'(DW)) drive(1'b0, 1'b0);
            check_eq("rnd_val",  32'(deser_data_val_o), 32'h1);
            check_eq("rnd_data", 32'(deser_data_o), 32'(word & mask));
            check_eq("rnd_mod",  32'(deser_data_mod_o), 32'(mod));
        end

        repeat (2) @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_deserializer
